// File: rtl/main.sv
// Morse keyer: transmits one ASCII letter, digit or word space per Start
// request as International Morse on the registered key output Y.
module main #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] RxData,
  input  logic       Start,
  output logic       Y
);

  localparam int CW = (UNIT_CYCLES * 3 > 2) ? $clog2(UNIT_CYCLES * 3) : 2;
  localparam logic [CW-1:0] UNIT_LAST   = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] TRIPLE_LAST = CW'(UNIT_CYCLES * 3 - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MARK       = 2'd1,
    GAP        = 2'd2,
    LETTER_GAP = 2'd3
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       space;
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  function automatic code_t mk(input logic [2:0] len, input logic [4:0] pat);
    code_t c;
    c.valid = 1'b1;
    c.space = 1'b0;
    c.len   = len;
    c.pat   = pat;
    return c;
  endfunction

  // Element i of a code lives in pat[i]; 1 = dash, 0 = dot.
  function automatic code_t decode(input logic [6:0] ch);
    logic [6:0] u;
    code_t      c;
    u = ((ch >= 7'd97) && (ch <= 7'd122)) ? (ch - 7'd32) : ch;
    case (u)
      7'd32: begin
        c       = '0;
        c.valid = 1'b1;
        c.space = 1'b1;
      end
      7'd65: c = mk(3'd2, 5'b00010);
      7'd66: c = mk(3'd4, 5'b00001);
      7'd67: c = mk(3'd4, 5'b00101);
      7'd68: c = mk(3'd3, 5'b00001);
      7'd69: c = mk(3'd1, 5'b00000);
      7'd70: c = mk(3'd4, 5'b00100);
      7'd71: c = mk(3'd3, 5'b00011);
      7'd72: c = mk(3'd4, 5'b00000);
      7'd73: c = mk(3'd2, 5'b00000);
      7'd74: c = mk(3'd4, 5'b01110);
      7'd75: c = mk(3'd3, 5'b00101);
      7'd76: c = mk(3'd4, 5'b00010);
      7'd77: c = mk(3'd2, 5'b00011);
      7'd78: c = mk(3'd2, 5'b00001);
      7'd79: c = mk(3'd3, 5'b00111);
      7'd80: c = mk(3'd4, 5'b00110);
      7'd81: c = mk(3'd4, 5'b01011);
      7'd82: c = mk(3'd3, 5'b00010);
      7'd83: c = mk(3'd3, 5'b00000);
      7'd84: c = mk(3'd1, 5'b00001);
      7'd85: c = mk(3'd3, 5'b00100);
      7'd86: c = mk(3'd4, 5'b01000);
      7'd87: c = mk(3'd3, 5'b00110);
      7'd88: c = mk(3'd4, 5'b01001);
      7'd89: c = mk(3'd4, 5'b01101);
      7'd90: c = mk(3'd4, 5'b00011);
      7'd48: c = mk(3'd5, 5'b11111);
      7'd49: c = mk(3'd5, 5'b11110);
      7'd50: c = mk(3'd5, 5'b11100);
      7'd51: c = mk(3'd5, 5'b11000);
      7'd52: c = mk(3'd5, 5'b10000);
      7'd53: c = mk(3'd5, 5'b00000);
      7'd54: c = mk(3'd5, 5'b00001);
      7'd55: c = mk(3'd5, 5'b00011);
      7'd56: c = mk(3'd5, 5'b00111);
      7'd57: c = mk(3'd5, 5'b01111);
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [2:0]    len_r;
  logic [4:0]    pat_r;
  logic          space_r;
  code_t         dec_s;
  logic [CW-1:0] mark_last_s;

  // Decode the live character and pick the length of the current element.
  always_comb begin
    dec_s = decode(RxData);
    if (pat_r[idx_r]) begin
      mark_last_s = TRIPLE_LAST;
    end else begin
      mark_last_s = UNIT_LAST;
    end
  end

  // Keyer FSM; Y follows the MARK state one cycle later so it is a pure flop.
  // A word space is LETTER_GAP + GAP + LETTER_GAP = 7 silent units.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= 3'd0;
      len_r   <= 3'd0;
      pat_r   <= 5'd0;
      space_r <= 1'b0;
      Y       <= 1'b0;
    end else begin
      Y <= (state_r == MARK);
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          idx_r <= 3'd0;
          if (Start && dec_s.valid) begin
            len_r   <= dec_s.len;
            pat_r   <= dec_s.pat;
            space_r <= dec_s.space;
            state_r <= dec_s.space ? LETTER_GAP : MARK;
          end else begin
            state_r <= IDLE;
          end
        end
        MARK: begin
          if (cnt_r == mark_last_s) begin
            cnt_r <= '0;
            if (idx_r == (len_r - 3'd1)) begin
              state_r <= LETTER_GAP;
            end else begin
              idx_r   <= idx_r + 3'd1;
              state_r <= GAP;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        GAP: begin
          if (cnt_r == UNIT_LAST) begin
            cnt_r   <= '0;
            state_r <= (len_r == 3'd0) ? LETTER_GAP : MARK;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        LETTER_GAP: begin
          if (cnt_r == TRIPLE_LAST) begin
            cnt_r <= '0;
            if (space_r) begin
              space_r <= 1'b0;
              state_r <= GAP;
            end else begin
              state_r <= IDLE;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          cnt_r   <= '0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_main.sv
// Directed bench for the Morse keyer at UNIT_CYCLES=1 with hand-computed
// Y sequences (one character per cycle of the expected string).
module tb_main;

  logic       CLK;
  logic       RST;
  logic [6:0] RxData;
  logic       Start;
  logic       Y;

  int vec_cnt = 0;
  int err_cnt = 0;

  main #(.UNIT_CYCLES(1)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .RxData(RxData),
    .Start (Start),
    .Y     (Y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic got, input logic exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: Y=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One-cycle Start pulse, then Y compared cycle by cycle against pat.
  task automatic xmit(input string tag, input logic [6:0] ch, input string pat);
    RxData = ch;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    chk({tag, "_lat"}, Y, 1'b0);
    for (int i = 0; i < pat.len(); i++) begin
      tick();
      chk($sformatf("%s[%0d]", tag, i), Y, pat[i] == 8'h31);
    end
  endtask

  initial begin
    RST    = 1'b0;
    Start  = 1'b0;
    RxData = 7'd0;
    #22;
    chk("reset", Y, 1'b0);
    RST = 1'b1;

    xmit("A", 7'd65, "10111000");
    xmit("S", 7'd83, "10101000");
    xmit("T", 7'd84, "111000");
    xmit("e_lower", 7'd101, "1000");
    xmit("five", 7'd53, "101010101000");
    xmit("zero", 7'd48, "1110111011101110111000");
    xmit("at_invalid", 7'd64, "0000");
    xmit("space", 7'd32, "0000000");
    xmit("E_after_space", 7'd69, "1000");

    // Start during the letter gap of 'E' must be dropped, not queued.
    RxData = 7'd69;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    chk("ET_lat", Y, 1'b0);
    tick();
    chk("ET_dot", Y, 1'b1);
    RxData = 7'd84;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("ET_drop[%0d]", i), Y, 1'b0);
      tick();
    end

    // RxData changes without Start are ignored.
    for (int c = 65; c <= 75; c++) begin
      RxData = 7'(c);
      tick();
      chk($sformatf("sweep_%0d_a", c), Y, 1'b0);
      tick();
      chk($sformatf("sweep_%0d_b", c), Y, 1'b0);
    end
    xmit("K", 7'd75, "111010111000");

    // Reset during the dash of 'A' clears Y at once and aborts the letter.
    RxData = 7'd65;
    Start  = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    chk("rA_dot", Y, 1'b1);
    tick();
    chk("rA_gap", Y, 1'b0);
    tick();
    chk("rA_dash", Y, 1'b1);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_async", Y, 1'b0);
    tick();
    chk("rst_hold", Y, 1'b0);
    #3;
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("no_resume[%0d]", i), Y, 1'b0);
    end
    xmit("E_after_rst", 7'd69, "1000");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
